// File: rtl/hamming_secded_decoder_pipe.sv
// Pipelined Hamming SECDED decoder: stage 1 registers syndrome/overall parity,
// stage 2 registers corrected data and flags; saturating error statistics.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int P = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int N = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      code_in,
    input  logic              parity_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              error,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [P-1:0]      err_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorrectable
);

    localparam logic [P-1:0] LAST_POS = P'(N - 1);

    logic [P-1:0]      syn_c;
    logic              g_c;
    logic              s1_valid;
    logic [N-1:0]      s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_g;
    logic              stage2_adv;
    logic              correctable;
    logic              uncorrectable;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] data_c;

    assign stage2_adv = !out_valid || out_ready;
    assign in_ready   = !s1_valid || stage2_adv;
    assign error      = err_corrected || err_uncorrectable;

    // parity_type is folded into syndrome and g here, so it need not travel further
    always_comb begin
        syn_c = '0;
        for (int unsigned pos = 1; pos < N; pos++) begin
            for (int unsigned k = 0; k < P; k++) begin
                if (((pos >> k) & 32'd1) != 0) begin
                    syn_c[k] = syn_c[k] ^ code_in[pos];
                end
            end
        end
        syn_c = syn_c ^ {P{parity_type}};
        g_c   = (^code_in) ^ parity_type;
    end

    always_comb begin
        int unsigned j;
        correctable   = s1_g && (s1_syn <= LAST_POS);
        uncorrectable = (s1_g && (s1_syn > LAST_POS)) || (!s1_g && (s1_syn != '0));
        fixed         = s1_code;
        if (correctable) begin
            fixed[s1_syn] = ~fixed[s1_syn];
        end
        data_c = '0;
        j      = 0;
        for (int unsigned pos = 3; pos < N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_c[j] = fixed[pos];
                j++;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_g     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
                s1_syn  <= syn_c;
                s1_g    <= g_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            data_out          <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_pos           <= '0;
        end else if (stage2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out          <= data_c;
                err_corrected     <= correctable;
                err_uncorrectable <= uncorrectable;
                err_pos           <= correctable ? s1_syn : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corrected     <= '0;
            cnt_uncorrectable <= '0;
        end else if (cnt_clr) begin
            cnt_corrected     <= '0;
            cnt_uncorrectable <= '0;
        end else if (out_valid && out_ready) begin
            if (err_corrected && (cnt_corrected != '1)) begin
                cnt_corrected <= cnt_corrected + CNT_W'(1);
            end
            if (err_uncorrectable && (cnt_uncorrectable != '1)) begin
                cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
            end
        end
    end

endmodule
